// File: rtl/tcam_rep_policy.sv
// 256-entry fully-associative tag store with selectable victim policy (FIFO / tree PLRU / LFSR random).
// Lookup, victim index and victim tag are all combinational; tag and policy state update on CLK.
module tcam_rep_policy #(
  parameter int POLICY = 0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Valid,
  input  logic        Hit,
  input  logic [31:0] Addr,
  output logic        h,
  output logic [7:0]  Hit_Index,
  output logic [7:0]  RepPtr,
  output logic [27:0] replaced_Tag
);

  localparam int N = 256;

  logic [27:0]  tag_q [N];
  logic [N-1:0] tv_q;
  logic [7:0]   fifo_q;
  logic [254:0] plru_q, plru_d;
  logic [7:0]   lfsr_q, lfsr_d;

  logic [27:0]  key;
  logic [N-1:0] match;
  logic [7:0]   plru_victim;
  logic [7:0]   acc_idx;
  logic         unused_addr;

  assign key         = Addr[31:4];
  assign unused_addr = ^Addr[3:0];

  always_comb begin
    for (int i = 0; i < N; i++) match[i] = tv_q[i] && (tag_q[i] == key);
  end

  assign h = |match;

  // Scan downward so the lowest matching index is the last one written.
  always_comb begin
    Hit_Index = '0;
    for (int i = N-1; i >= 0; i--) if (match[i]) Hit_Index = 8'(i);
  end

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
  always_comb begin
    logic [7:0] node;
    logic       b;
    node        = '0;
    plru_victim = '0;
    for (int l = 0; l < 8; l++) begin
      b                  = plru_q[node];
      plru_victim[7-l]   = b;
      node               = (node << 1) + 8'd1 + {7'd0, b};
    end
  end

  assign acc_idx = Hit ? Hit_Index : RepPtr;

  always_comb begin
    logic [7:0] node;
    logic       b;
    plru_d = plru_q;
    node   = '0;
    for (int l = 0; l < 8; l++) begin
      b            = acc_idx[7-l];
      plru_d[node] = ~b;
      node         = (node << 1) + 8'd1 + {7'd0, b};
    end
  end

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1; zero is unreachable from a nonzero seed.
  assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

  always_comb begin
    case (POLICY)
      1:       RepPtr = plru_victim;
      2:       RepPtr = lfsr_q;
      default: RepPtr = fifo_q;
    endcase
  end

  assign replaced_Tag = tag_q[RepPtr];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) tag_q[i] <= '0;
      tv_q   <= '0;
      fifo_q <= '0;
      plru_q <= '0;
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= lfsr_d;
      if (Valid) begin
        plru_q <= plru_d;
        if (!Hit) begin
          tag_q[RepPtr] <= key;
          tv_q[RepPtr]  <= 1'b1;
          fifo_q        <= fifo_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tcam_rep_policy.sv
// Directed bench: one instance per policy sharing stimulus, checked against hand-derived values.
module tb_tcam_rep_policy;

  logic        CLK = 0;
  logic        Reset, Valid, Hit;
  logic [31:0] Addr;

  logic        hf, hp, hr;
  logic [7:0]  hif, hip, hir;
  logic [7:0]  rpf, rpp, rpr;
  logic [27:0] rtf, rtp, rtr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  tcam_rep_policy #(.POLICY(0)) u_fifo (.CLK(CLK), .Reset(Reset), .Valid(Valid), .Hit(Hit), .Addr(Addr),
    .h(hf), .Hit_Index(hif), .RepPtr(rpf), .replaced_Tag(rtf));
  tcam_rep_policy #(.POLICY(1)) u_plru (.CLK(CLK), .Reset(Reset), .Valid(Valid), .Hit(Hit), .Addr(Addr),
    .h(hp), .Hit_Index(hip), .RepPtr(rpp), .replaced_Tag(rtp));
  tcam_rep_policy #(.POLICY(2)) u_rand (.CLK(CLK), .Reset(Reset), .Valid(Valid), .Hit(Hit), .Addr(Addr),
    .h(hr), .Hit_Index(hir), .RepPtr(rpr), .replaced_Tag(rtr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle just after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic hi, input logic [27:0] t);
    Reset = r; Valid = v; Hit = hi; Addr = {t, 4'h0};
    #4;
  endtask

  function automatic logic [7:0] brev(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = x[7-i];
    return y;
  endfunction

  logic [7:0] rnd_exp [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
  logic [27:0] dup_tags [8] = '{28'h10, 28'h11, 28'h12, 28'h77, 28'h14, 28'h15, 28'h16, 28'h77};
  logic [255:0] seen;
  int bad;

  initial begin
    Reset = 1; Valid = 0; Hit = 0; Addr = '0;
    #1;

    // Reset together with a miss request: no install
    drive(1, 1, 0, 28'h1); step();
    drive(0, 0, 0, 28'h1);
    chk("rst_h", hf, 0);
    chk("rst_hidx", hif, 0);
    chk("rst_rtag", rtf, 0);
    chk("rst_rep_fifo", rpf, 0);
    chk("rst_rep_plru", rpp, 0);
    chk("rst_rep_rand", rpr, 1);
    step();

    // First miss, then hit on the next cycle
    drive(1, 0, 0, 28'h1); step();
    drive(0, 1, 0, 28'h1);
    chk("miss1_h", hf, 0);
    chk("miss1_rep", rpf, 0);
    step();
    drive(0, 0, 0, 28'h1);
    chk("hit1_h", hf, 1);
    chk("hit1_idx", hif, 0);
    step();

    // RANDOM sequence from reset
    drive(1, 0, 0, 28'h0); step();
    seen = '0; bad = 0;
    for (int k = 0; k < 255; k++) begin
      drive(0, 0, 0, 28'h0);
      if (k < 6) chk($sformatf("rand_seq%0d", k), rpr, rnd_exp[k]);
      if (rpr == 0 || seen[rpr]) bad++;
      seen[rpr] = 1'b1;
      step();
    end
    drive(0, 0, 0, 28'h0);
    chk("rand_distinct", bad, 0);
    chk("rand_period", rpr, 8'h01);
    step();

    // FIFO fill of 256 distinct tags; PLRU victims follow bit-reversed order
    drive(1, 0, 0, 28'h0); step();
    for (int k = 0; k < 256; k++) begin
      drive(0, 1, 0, 28'(k + 1));
      chk($sformatf("fifo_fill%0d", k), rpf, k);
      chk($sformatf("plru_fill%0d", k), rpp, brev(8'(k)));
      step();
    end
    drive(0, 0, 0, 28'h5);
    chk("fifo_wrap", rpf, 0);
    chk("plru_wrap", rpp, 0);
    chk("fifo_look5_h", hf, 1);
    chk("fifo_look5_idx", hif, 4);
    step();
    drive(0, 1, 1, 28'h5); step();
    drive(0, 1, 0, 28'd300);
    chk("fifo_hit_norep", rpf, 0);
    chk("fifo_257_rtag", rtf, 1);
    step();
    drive(0, 0, 0, 28'd300);
    chk("fifo_257_rep", rpf, 1);
    chk("fifo_257_h", hf, 1);
    chk("fifo_257_idx", hif, 0);
    step();
    drive(0, 0, 0, 28'd1);
    chk("fifo_evicted_h", hf, 0);
    chk("fifo_evicted_idx", hif, 0);
    step();

    // PLRU: two installs (entries 0 and 128), hit on entry 0
    drive(1, 0, 0, 28'h0); step();
    drive(0, 1, 0, 28'hA); step();
    drive(0, 0, 0, 28'hA);
    chk("plru_after1", rpp, 128);
    step();
    drive(0, 1, 0, 28'hB); step();
    drive(0, 0, 0, 28'hB);
    chk("plru_after2", rpp, 64);
    chk("plru_b_idx", hip, 128);
    step();
    drive(0, 1, 1, 28'hA);
    chk("plru_hit_h", hp, 1);
    chk("plru_hit_idx", hip, 0);
    step();
    drive(0, 0, 0, 28'hA);
    chk("plru_hit_rep", rpp, 192);
    chk("plru_hit_not0", rpp != 0, 1);
    step();

    // Duplicate tags in entries 3 and 7
    drive(1, 0, 0, 28'h0); step();
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 0, dup_tags[k]); step();
    end
    drive(0, 0, 0, 28'h77);
    chk("dup_h", hf, 1);
    chk("dup_idx", hif, 3);
    step();
    drive(0, 0, 0, 28'h99);
    chk("nomatch_h", hf, 0);
    chk("nomatch_idx", hif, 0);
    step();

    // Reset mid-sequence overrides a miss
    drive(1, 1, 0, 28'h77); step();
    drive(0, 0, 0, 28'h77);
    chk("midrst_h", hf, 0);
    chk("midrst_rep", rpf, 0);
    chk("midrst_rtag", rtf, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
